bram_capture_ctrl: RTL and testbench
====================================

Name: bram_capture_ctrl

Overview:
Parametrised multi-channel sample-capture controller that writes decimated PDH data into a simple-dual-port BRAM.
- Generalises the single-channel, fixed-mode BRAM controller: configurable channel count, data width and depth.
- Adds one-shot and circular capture modes, a latched decimation code, and done/wrap/count status.
- Sits between the PDH datapath (error/feedback signals) and the BRAM write port; the readout path reads BRAM independently.

Parameters:
- NUM_CH, 2, number of packed input channels.
- DATA_W, 14, bits per channel sample.
- ADDR_W, 14, BRAM address width; depth = 2**ADDR_W.
- DIV_W, 26, width of the decimation code.

Ports:
- pdh_clk  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  level; high starts capture from IDLE, low stops capture.
- mode_i  in  1  0 = one-shot, 1 = circular; latched on capture start.
- divcode_i  in  DIV_W  decimation code; sample period = divcode+1 cycles; latched on capture start.
- clear_i  in  1  pulse; DONE -> IDLE.
- ch_data_i  in  NUM_CH*DATA_W  packed channel samples, ch0 in the LSBs.
- bram_we_o  out  1  BRAM write enable.
- bram_addr_o  out  ADDR_W  BRAM write address.
- bram_wdata_o  out  NUM_CH*DATA_W  BRAM write data.
- busy_o  out  1  high in CAPTURE (and ARMED).
- done_o  out  1  high in DONE.
- wrapped_o  out  1  circular mode has overwritten address 0 at least once.
- wr_count_o  out  ADDR_W+1  writes since start, saturating at 2**ADDR_W.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including bram_wdata_o and bram_addr_o.
- States: IDLE, CAPTURE, DONE (plus ARMED with the optional feature).
- IDLE:
  - On enable_i=1: latch divcode_i and mode_i; clear address, divider counter, wr_count_o and wrapped_o; go to CAPTURE.
- CAPTURE:
  - Divider counts 0..div_latched. The strobe fires on the first CAPTURE cycle and then every div_latched+1 cycles.
  - On a strobe cycle, ch_data_i is registered. On the next cycle: bram_we_o=1, bram_wdata_o = registered data, bram_addr_o = current address. The address increments after the write.
  - Fixed latency: strobe to write = 1 cycle. bram_we_o is never high for two consecutive cycles unless divcode=0.
  - One-shot: the write to address 2**ADDR_W-1 is the last; next state DONE. Later strobes are ignored.
  - Circular: the address wraps to 0 after the last address. wrapped_o goes high on the first write to address 0 after a wrap. Capture continues.
  - enable_i=0 -> DONE. A write pending from a strobe in the previous cycle still completes in the same cycle the state changes.
- DONE:
  - done_o=1; bram_addr_o holds the last written address; wr_count_o and wrapped_o hold.
  - enable_i is ignored. clear_i=1 -> IDLE, and done_o returns to 0 on the next cycle.
- Simultaneous events:
  - clear_i is ignored outside DONE.
  - A one-shot final write coinciding with enable_i=0 -> DONE, with the write performed.
- divcode_i and mode_i changes during CAPTURE have no effect until the next start.
- wr_count_o saturates at 2**ADDR_W in circular mode.
- Reset mid-capture: immediate return to reset values; no further writes.

Optional Feature:
- Macro: BRAM_CAPTURE_TRIG_EN.
- Defined:
  - Adds input trig_i (1 bit) and state ARMED.
  - IDLE + enable_i -> ARMED. busy_o=1 in ARMED; the divider is held at 0.
  - trig_i=1 in ARMED -> CAPTURE; the first strobe occurs in the first CAPTURE cycle.
  - enable_i=0 in ARMED -> IDLE with no writes and done_o not set.
- Undefined: no trig_i port and no ARMED state; IDLE goes straight to CAPTURE.

Decomposition:
- Package pdh_capture_pkg holds:
  - state enum (IDLE, ARMED, CAPTURE, DONE);
  - mode enum (MODE_ONESHOT, MODE_CIRC);
  - default width localparams (DATA_W=14, DIV_W=26).
- Sub-module decim_strobe (parameter DIV_W): inputs pdh_clk, rst_ni, run_i, div_i; output strobe_o. The counter and the first-cycle strobe rule live here.
- The controller holds the FSM, address counter, data register and status.

Test Plan:
- divcode=3, one-shot, ADDR_W=4, ch_data ramps by 1 per cycle:
  - bram_we_o high every 4th cycle at addresses 0..15;
  - wdata equals the ramp value from the strobe cycle;
  - after the 16th write, done_o=1 and wr_count_o=16.
- divcode=0, circular, ADDR_W=4, enable held for 40 cycles:
  - a write every cycle;
  - the 17th write goes to address 0 and sets wrapped_o=1;
  - after enable drops, DONE with wr_count_o=16 (saturated).
- divcode=3, enable dropped after the 5th write:
  - DONE, wr_count_o=5, bram_addr_o=4;
  - clear_i -> IDLE with done_o=0 one cycle later.
- Change divcode_i from 3 to 7 mid-capture -> write spacing stays at 4 cycles.
- Assert rst_ni low mid-capture (asynchronously, between clock edges) -> all outputs 0 immediately; no bram_we_o after release until enable_i is seen.
- With BRAM_CAPTURE_TRIG_EN defined:
  - enable_i held 20 cycles without trig_i -> no writes, busy_o=1;
  - trig_i pulse -> first write 1 cycle after CAPTURE entry, at address 0.

Source files
------------

// File: rtl/pdh_capture_pkg.sv
// pdh_capture_pkg: shared state/mode types and default widths for the BRAM capture controller
package pdh_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  typedef enum logic {MODE_ONESHOT, MODE_CIRC} mode_t;
  localparam int DEF_DATA_W = 14;
  localparam int DEF_DIV_W  = 26;
endpackage

// File: rtl/decim_strobe.sv
// decim_strobe: decimation strobe, fires on the first run cycle and then every div_i+1 cycles
module decim_strobe import pdh_capture_pkg::*; #(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             pdh_clk,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             strobe_o
);
  logic [DIV_W-1:0] cnt;
  assign strobe_o = run_i && cnt == '0;
  always_ff @(posedge pdh_clk or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else cnt <= (!run_i || cnt == div_i) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: one-shot/circular decimated multi-channel capture into a BRAM write port.
// Define BRAM_CAPTURE_TRIG_EN to add trig_i and an ARMED state between IDLE and CAPTURE.
module bram_capture_ctrl import pdh_capture_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 14,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic                     pdh_clk,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     mode_i,
  input  logic [DIV_W-1:0]         divcode_i,
  input  logic                     clear_i,
`ifdef BRAM_CAPTURE_TRIG_EN
  input  logic                     trig_i,
`endif
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic                     bram_we_o,
  output logic [ADDR_W-1:0]        bram_addr_o,
  output logic [NUM_CH*DATA_W-1:0] bram_wdata_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     wrapped_o,
  output logic [ADDR_W:0]          wr_count_o
);
`ifdef BRAM_CAPTURE_TRIG_EN
  localparam state_t START_ST = ARMED;
`else
  localparam state_t START_ST = CAPTURE;
`endif
  state_t state, state_nx;
  mode_t mode_r;
  logic [DIV_W-1:0] div_r;
  logic [ADDR_W-1:0] nxt_addr;
  logic strobe, accept, start, full;
  decim_strobe #(.DIV_W(DIV_W)) u_decim (
    .pdh_clk  (pdh_clk),
    .rst_ni   (rst_ni),
    .run_i    (state == CAPTURE),
    .div_i    (div_r),
    .strobe_o (strobe)
  );
  // full: every address has been issued once; in one-shot this blocks further strobes
  assign full   = wr_count_o[ADDR_W];
  assign accept = strobe && state == CAPTURE && enable_i && !(mode_r == MODE_ONESHOT && full);
  assign start  = state == IDLE && enable_i;
  assign busy_o = state == CAPTURE || state == ARMED;
  assign done_o = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable_i ? START_ST : IDLE;
`ifdef BRAM_CAPTURE_TRIG_EN
      ARMED:   state_nx = !enable_i ? IDLE : trig_i ? CAPTURE : ARMED;
`endif
      CAPTURE: state_nx = (!enable_i || (mode_r == MODE_ONESHOT && bram_we_o && full)) ? DONE : CAPTURE;
      DONE:    state_nx = clear_i ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge pdh_clk or negedge rst_ni)
    if (!rst_ni) begin
      state        <= IDLE;
      mode_r       <= MODE_ONESHOT;
      div_r        <= '0;
      nxt_addr     <= '0;
      bram_we_o    <= 1'b0;
      bram_addr_o  <= '0;
      bram_wdata_o <= '0;
      wrapped_o    <= 1'b0;
      wr_count_o   <= '0;
    end else begin
      state     <= state_nx;
      bram_we_o <= accept;
      if (start) begin
        div_r       <= divcode_i;
        mode_r      <= mode_t'(mode_i);
        nxt_addr    <= '0;
        bram_addr_o <= '0;
        wr_count_o  <= '0;
        wrapped_o   <= 1'b0;
      end
      if (accept) begin
        bram_wdata_o <= ch_data_i;
        bram_addr_o  <= nxt_addr;
        nxt_addr     <= nxt_addr + ADDR_W'(1);
        if (!full) wr_count_o <= wr_count_o + (ADDR_W+1)'(1);
        if (nxt_addr == '0 && wr_count_o != '0) wrapped_o <= 1'b1;
      end
    end
endmodule

// File: tb/tb_bram_capture_ctrl.sv
// tb_bram_capture_ctrl: randomized capture scenarios checked against an arithmetic write-schedule model
module tb_bram_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 28;
  localparam int DEPTH = 1 << AW;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; logic wrap; logic [AW:0] cnt;} wr_t;
  logic pdh_clk = 0, rst_ni = 0, enable_i = 0, mode_i = 0, clear_i = 0;
  logic [25:0] divcode_i = '0;
  logic [DW-1:0] ch_data_i = '0;
`ifdef BRAM_CAPTURE_TRIG_EN
  logic trig_i = 0;
`endif
  logic bram_we_o, busy_o, done_o, wrapped_o;
  logic [AW-1:0] bram_addr_o;
  logic [DW-1:0] bram_wdata_o;
  logic [AW:0] wr_count_o;
  int cyc = 0, tests = 0, errs = 0;
  logic [DW-1:0] dbase = '0, dstep = 28'd1;
  wr_t wq[$];

  bram_capture_ctrl #(.NUM_CH(2), .DATA_W(14), .ADDR_W(AW), .DIV_W(26)) dut (
    .pdh_clk      (pdh_clk),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .divcode_i    (divcode_i),
    .clear_i      (clear_i),
`ifdef BRAM_CAPTURE_TRIG_EN
    .trig_i       (trig_i),
`endif
    .ch_data_i    (ch_data_i),
    .bram_we_o    (bram_we_o),
    .bram_addr_o  (bram_addr_o),
    .bram_wdata_o (bram_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .wrapped_o    (wrapped_o),
    .wr_count_o   (wr_count_o)
  );

  always #5 pdh_clk = ~pdh_clk;

  function automatic logic [DW-1:0] data_at(input int t);
    return dbase + dstep * DW'(t);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge pdh_clk);
    #2;
  endtask

  initial forever begin
    @(posedge pdh_clk);
    #1;
    cyc++;
    ch_data_i = data_at(cyc);
  end

  always @(negedge pdh_clk)
    if (rst_ni && bram_we_o) wq.push_back('{cyc, bram_addr_o, bram_wdata_o, wrapped_o, wr_count_o});

  task automatic run(input int d, input bit circ, input int dur);
    int s, e, n, last, cnt_exp;
    step();
    wq.delete();
    divcode_i = 26'(d);
    mode_i = circ;
    enable_i = 1;
    s = cyc;
`ifdef BRAM_CAPTURE_TRIG_EN
    repeat (20) step();
    check("armed_busy", busy_o, 1);
    check("armed_nowr", wq.size(), 0);
    trig_i = 1;
    s = cyc;
    step();
    trig_i = 0;
`else
    step();
`endif
    divcode_i = 26'(d + 4);
    check("cap_busy", busy_o, 1);
    check("cap_done", done_o, 0);
    while (cyc < s + dur) step();
    enable_i = 0;
    e = cyc;
    n = 0;
    for (int t = s + 1; t < e && (circ || n < DEPTH); t += d + 1) n++;
    last = e;
    if (n > 0 && s + 2 + (n - 1) * (d + 1) > last) last = s + 2 + (n - 1) * (d + 1);
    while (cyc < last + 2) step();
    cnt_exp = n > DEPTH ? DEPTH : n;
    check("n_writes", wq.size(), n);
    check("done", done_o, 1);
    check("busy_done", busy_o, 0);
    check("we_done", bram_we_o, 0);
    check("count", wr_count_o, cnt_exp);
    check("last_addr", bram_addr_o, n > 0 ? (n - 1) % DEPTH : 0);
    check("wrapped", wrapped_o, circ && n > DEPTH);
    foreach (wq[k]) begin
      check("wr_cyc", wq[k].cyc, s + 2 + k * (d + 1));
      check("wr_addr", wq[k].addr, k % DEPTH);
      check("wr_data", wq[k].data, data_at(s + 1 + k * (d + 1)));
      check("wr_cnt", wq[k].cnt, k + 1 > DEPTH ? DEPTH : k + 1);
      check("wr_wrap", wq[k].wrap, k >= DEPTH);
    end
    enable_i = 1;
    step();
    check("done_ign_en", done_o, 1);
    enable_i = 0;
    clear_i = 1;
    check("done_pre_clr", done_o, 1);
    step();
    clear_i = 0;
    check("done_clr", done_o, 0);
    check("busy_clr", busy_o, 0);
  endtask

  initial begin
    #3;
    check("rst_we", bram_we_o, 0);
    check("rst_addr", bram_addr_o, 0);
    check("rst_wdata", bram_wdata_o, 0);
    check("rst_stat", {busy_o, done_o, wrapped_o}, 0);
    check("rst_cnt", wr_count_o, 0);
    repeat (3) @(posedge pdh_clk);
    @(negedge pdh_clk) rst_ni = 1;
    run(3, 0, 80);
    run(0, 1, 40);
    run(3, 0, 19);
    dbase = 28'($urandom);
    dstep = 28'($urandom);
    for (int i = 0; i < 8; i++) run($urandom_range(0, 7), 1'($urandom), $urandom_range(2, 150));
    step();
    divcode_i = 26'd1;
    mode_i = 1;
    enable_i = 1;
    repeat (10) step();
    check("pre_rst_busy", busy_o, 1);
    #1 rst_ni = 0;
    #1;
    check("arst_we", bram_we_o, 0);
    check("arst_addr", bram_addr_o, 0);
    check("arst_wdata", bram_wdata_o, 0);
    check("arst_stat", {busy_o, done_o, wrapped_o}, 0);
    check("arst_cnt", wr_count_o, 0);
    enable_i = 0;
    step();
    step();
    @(negedge pdh_clk) rst_ni = 1;
    wq.delete();
    repeat (10) step();
    check("post_rst_nowr", wq.size(), 0);
    check("post_rst_busy", busy_o, 0);
    run($urandom_range(0, 7), 1, 60);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, errs + 1);
    $fatal(1, "timeout");
  end
endmodule
